// File: rtl/pc_ir_sequencer.sv
// pc_ir_sequencer: program counter, instruction register and FETCH/EXEC
// sequencer for the nic8 core. It feeds the instruction decoder with `ir`.
// It advances `pc` from the decoder's loadIR/doJump/immediate strobes.
// It drives the memory address bus and the `exec` phase strobe.
//
// Optional feature: define SEQ_HALT_EN to add a HALT state. Executing an
// instruction whose dest field is 7 then stops the core until reset.
// Without the macro, dest 7 runs as an ordinary instruction and `halted`
// is tied low.
//
// Handshake: `mem_ready` is a single-sided ready. A transfer completes on
// any rising clk edge where mem_ready=1. When mem_ready=0, every register
// holds, and the combinational outputs keep their current values.
module pc_ir_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_ready,
   input  logic [7:0]  dbus,
   input  logic [7:0]  x,
   input  logic        loadIR,
   input  logic        doJump,
   input  logic        immediate,
   output logic [7:0]  ir,
   output logic [7:0]  pc,
   output logic [7:0]  addr,
   output logic        exec,
   output logic        halted,
   output logic [15:0] instr_count,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_pc;
   logic [7:0]  w_pc_next;
   logic [7:0]  r_ir;
   logic [7:0]  w_ir_next;
   logic [15:0] r_instr_count;
   logic [15:0] w_instr_count_next;
   logic        w_dest7;

   // Dest field 7 is unused by the decoder; it is the halt opcode when enabled.
   assign w_dest7 = (r_ir[3:1] == 3'd7);

   // State, PC, IR and instruction counter registers with async reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_pc          <= 8'h00;
         r_ir          <= 8'h00;
         r_instr_count <= 16'h0000;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_ir          <= w_ir_next;
         r_instr_count <= w_instr_count_next;
      end
   end

   // Next-state and datapath update; everything holds while mem_ready is low.
   always_comb begin
      w_state_next       = r_state;
      w_pc_next          = r_pc;
      w_ir_next          = r_ir;
      w_instr_count_next = r_instr_count;
      if (mem_ready) begin
         case (r_state)
            S_FETCH: begin
               // Decoder strobes reflect a stale ir here and are ignored.
               w_ir_next    = dbus;
               w_pc_next    = r_pc + 8'd1;
               w_state_next = S_EXEC;
            end
            S_EXEC: begin
               // A jump overrides the operand-byte increment.
               if (doJump) begin
                  w_pc_next = dbus;
               end else if (immediate) begin
                  w_pc_next = r_pc + 8'd1;
               end
               w_instr_count_next = r_instr_count + 16'd1;
`ifdef SEQ_HALT_EN
               if (w_dest7) begin
                  w_state_next = S_HALT;
               end else
`endif
               if (loadIR) begin
                  // Chained instruction: the data byte is the next opcode.
                  w_ir_next    = dbus;
                  w_state_next = S_EXEC;
               end else begin
                  w_state_next = S_FETCH;
               end
            end
            S_HALT: begin
               w_state_next = S_HALT;
            end
            default: begin
               w_state_next = S_FETCH;
            end
         endcase
      end
   end

   // The address is the operand pointer in EXEC and the pc in every other state.
   always_comb begin
      addr = r_pc;
      if (r_state == S_EXEC && !immediate) begin
         addr = x;
      end
   end

   assign exec        = (r_state == S_EXEC);
`ifdef SEQ_HALT_EN
   assign halted      = (r_state == S_HALT);
`else
   assign halted      = 1'b0;
   // The halt opcode decode has no effect in this build.
   logic w_unused_dest7;
   assign w_unused_dest7 = w_dest7;
`endif
   assign ir          = r_ir;
   assign pc          = r_pc;
   assign instr_count = r_instr_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_ir_sequencer.sv
// Directed testbench for pc_ir_sequencer. A table of per-cycle vectors
// covers fetch, immediate, indexed, jump, chained loadIR, stalls and pc wrap.
// Hand-written sequences then cover HALT (or its absence) and an async reset
// asserted mid-EXEC.
module tb_pc_ir_sequencer;

   logic        clk;
   logic        reset;
   logic        mem_ready;
   logic [7:0]  dbus;
   logic [7:0]  x;
   logic        loadIR;
   logic        doJump;
   logic        immediate;
   logic [7:0]  ir;
   logic [7:0]  pc;
   logic [7:0]  addr;
   logic        exec;
   logic        halted;
   logic [15:0] instr_count;
   logic [1:0]  dbg_state;

   int n_checks;
   int n_errors;

   typedef struct {
      logic        mr;
      logic [7:0]  db;
      logic [7:0]  xv;
      logic        ld;
      logic        jp;
      logic        im;
      logic [7:0]  e_addr;   // before the edge
      logic        e_exec;   // before the edge
      logic [7:0]  e_ir;     // after the edge
      logic [7:0]  e_pc;     // after the edge
      logic [15:0] e_cnt;    // after the edge
   } vec_t;

   vec_t vecs[$];

   pc_ir_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .mem_ready   (mem_ready),
      .dbus        (dbus),
      .x           (x),
      .loadIR      (loadIR),
      .doJump      (doJump),
      .immediate   (immediate),
      .ir          (ir),
      .pc          (pc),
      .addr        (addr),
      .exec        (exec),
      .halted      (halted),
      .instr_count (instr_count),
      .o_dbg_state (dbg_state)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic mr, input logic [7:0] db, input logic [7:0] xv,
                      input logic ld, input logic jp, input logic im,
                      input logic [7:0] ea, input logic ee,
                      input logic [7:0] eir, input logic [7:0] epc, input logic [15:0] ecnt);
      vec_t v;
      v.mr = mr; v.db = db; v.xv = xv; v.ld = ld; v.jp = jp; v.im = im;
      v.e_addr = ea; v.e_exec = ee; v.e_ir = eir; v.e_pc = epc; v.e_cnt = ecnt;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic mr, input logic [7:0] db, input logic [7:0] xv,
                        input logic ld, input logic jp, input logic im);
      mem_ready = mr; dbus = db; x = xv; loadIR = ld; doJump = jp; immediate = im;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

      //   mr  dbus   x      ld  jp  im   addr  exec  ir     pc     cnt
      add(1, 8'h0C, 8'h00, 0, 0, 0, 8'h00, 0, 8'h0C, 8'h01, 16'd0); // fetch 0x0C
      add(1, 8'h55, 8'h00, 0, 0, 1, 8'h01, 1, 8'h0C, 8'h02, 16'd1); // immediate exec
      add(1, 8'h0D, 8'h00, 0, 0, 0, 8'h02, 0, 8'h0D, 8'h03, 16'd1); // fetch indexed
      add(1, 8'h99, 8'h80, 0, 0, 0, 8'h80, 1, 8'h0D, 8'h03, 16'd2); // addr=x, pc holds
      add(1, 8'h1C, 8'h00, 0, 0, 0, 8'h03, 0, 8'h1C, 8'h04, 16'd2); // fetch jump
      add(1, 8'h40, 8'h00, 0, 1, 1, 8'h04, 1, 8'h1C, 8'h40, 16'd3); // jump beats imm
      add(1, 8'h0C, 8'h00, 0, 0, 0, 8'h40, 0, 8'h0C, 8'h41, 16'd3); // fetch at target
      add(1, 8'h2B, 8'h00, 1, 0, 1, 8'h41, 1, 8'h2B, 8'h42, 16'd4); // chained load
      add(1, 8'h11, 8'h00, 0, 0, 1, 8'h42, 1, 8'h2B, 8'h43, 16'd5); // still EXEC
      add(0, 8'h77, 8'h00, 0, 0, 0, 8'h43, 0, 8'h2B, 8'h43, 16'd5); // fetch stall
      add(1, 8'h0D, 8'h00, 0, 0, 0, 8'h43, 0, 8'h0D, 8'h44, 16'd5); // fetch
      add(0, 8'h00, 8'h22, 0, 0, 0, 8'h22, 1, 8'h0D, 8'h44, 16'd5); // exec stall 1
      add(0, 8'h00, 8'h22, 0, 0, 0, 8'h22, 1, 8'h0D, 8'h44, 16'd5); // exec stall 2
      add(0, 8'h00, 8'h22, 0, 0, 0, 8'h22, 1, 8'h0D, 8'h44, 16'd5); // exec stall 3
      add(1, 8'h00, 8'h22, 0, 0, 0, 8'h22, 1, 8'h0D, 8'h44, 16'd6); // completes
      add(1, 8'h1C, 8'h00, 0, 0, 0, 8'h44, 0, 8'h1C, 8'h45, 16'd6); // fetch jump
      add(1, 8'hFF, 8'h10, 0, 1, 0, 8'h10, 1, 8'h1C, 8'hFF, 16'd7); // jump to 0xFF
      add(1, 8'h0D, 8'h00, 0, 0, 0, 8'hFF, 0, 8'h0D, 8'h00, 16'd7); // pc wraps
      add(1, 8'h00, 8'h33, 0, 0, 0, 8'h33, 1, 8'h0D, 8'h00, 16'd8); // indexed exec
      add(1, 8'h0E, 8'h00, 0, 0, 0, 8'h00, 0, 8'h0E, 8'h01, 16'd8); // fetch dest 7
      add(1, 8'h66, 8'h00, 0, 0, 1, 8'h01, 1, 8'h0E, 8'h02, 16'd9); // exec dest 7

      // Reset values, asserted asynchronously before any clock edge.
      #1;
      check("reset_pc", {8'h00, pc}, 16'h0000);
      check("reset_ir", {8'h00, ir}, 16'h0000);
      check("reset_cnt", instr_count, 16'h0000);
      check("reset_exec", {15'h0, exec}, 16'h0000);
      check("reset_halted", {15'h0, halted}, 16'h0000);
      check("reset_addr", {8'h00, addr}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].mr, vecs[i].db, vecs[i].xv, vecs[i].ld, vecs[i].jp, vecs[i].im);
         #1;
         check($sformatf("v%0d_addr", i), {8'h00, addr}, {8'h00, vecs[i].e_addr});
         check($sformatf("v%0d_exec", i), {15'h0, exec}, {15'h0, vecs[i].e_exec});
         check($sformatf("v%0d_halted", i), {15'h0, halted}, 16'h0000);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_ir", i), {8'h00, ir}, {8'h00, vecs[i].e_ir});
         check($sformatf("v%0d_pc", i), {8'h00, pc}, {8'h00, vecs[i].e_pc});
         check($sformatf("v%0d_cnt", i), instr_count, vecs[i].e_cnt);
      end

`ifdef SEQ_HALT_EN
      // Dest 7 halted the core: nothing may move for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1'b1, 8'h0C, 8'h00, 1'b1, 1'b1, 1'b1);
         #1;
         check("halt_halted", {15'h0, halted}, 16'h0001);
         check("halt_exec", {15'h0, exec}, 16'h0000);
         check("halt_addr", {8'h00, addr}, 16'h0002);
         @(posedge clk);
         #1;
         check("halt_pc", {8'h00, pc}, 16'h0002);
         check("halt_ir", {8'h00, ir}, 16'h000E);
         check("halt_cnt", instr_count, 16'd9);
      end
`else
      // Without the halt option, dest 7 returns to FETCH.
      @(negedge clk);
      drive(1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      check("nohalt_halted", {15'h0, halted}, 16'h0000);
      check("nohalt_exec", {15'h0, exec}, 16'h0000);
      check("nohalt_addr", {8'h00, addr}, 16'h0002);
      @(posedge clk);
      #1;
      check("nohalt_ir", {8'h00, ir}, 16'h000C);
      check("nohalt_pc", {8'h00, pc}, 16'h0003);
      check("nohalt_cnt", instr_count, 16'd9);
`endif

      // Async reset mid-EXEC: restart, fetch, then pulse reset between edges.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 8'h0D, 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("rst2_fetch_pc", {8'h00, pc}, 16'h0001);
      @(negedge clk);
      drive(1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0);
      #1;
      check("rst2_exec", {15'h0, exec}, 16'h0001);
      check("rst2_addr_x", {8'h00, addr}, 16'h0055);
      #2;
      reset = 1'b1;
      #1;
      check("async_pc", {8'h00, pc}, 16'h0000);
      check("async_ir", {8'h00, ir}, 16'h0000);
      check("async_exec", {15'h0, exec}, 16'h0000);
      check("async_addr", {8'h00, addr}, 16'h0000);
      check("async_cnt", instr_count, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      check("post_rst_addr", {8'h00, addr}, 16'h0000);
      check("post_rst_exec", {15'h0, exec}, 16'h0000);
      @(posedge clk);
      #1;
      check("post_rst_ir", {8'h00, ir}, 16'h000C);
      check("post_rst_pc", {8'h00, pc}, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_ir_sequencer.md
# pc_ir_sequencer

Program counter, instruction register and two-phase fetch/execute sequencer for the nic8 core. Sits directly upstream of the instruction decoder: it supplies the `ir` byte the decoder splits into bit7/bit6/source/dest/indexed. It consumes the decoder's `loadIR`, `doJump` and `immediate` outputs, which are active-high here, to advance the PC. It also drives the memory address bus and an `exec` phase strobe that downstream register triggers are gated with.

## Interface
Parameters: none (fixed 8-bit datapath).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `mem_ready`  input  1  memory handshake; 0 = stall, all state holds
- `dbus`  input  8  current data bus value (memory read data or selected source)
- `x`  input  8  X register, used as address for indexed operands
- `loadIR`  input  1  decoder: dest==0
- `doJump`  input  1  decoder: loadPC && jump condition
- `immediate`  input  1  decoder: ~indexed
- `ir`  output  8  instruction register, to decoder
- `pc`  output  8  program counter
- `addr`  output  8  memory address
- `exec`  output  1  1 while in EXEC state; gates decoder-driven writes
- `halted`  output  1  1 in HALT state (only with `SEQ_HALT_EN`)
- `instr_count`  output  16  completed-instruction counter

## Operation
- States: FETCH, EXEC, HALT (HALT reachable only with `SEQ_HALT_EN`).
- Reset (async): `pc`=0x00, `ir`=0x00, state=FETCH, `instr_count`=0, `halted`=0, so `exec`=0.
- FETCH: `addr`=`pc`. When `mem_ready`: `ir`<=`dbus`, `pc`<=`pc`+1, go to EXEC.
- EXEC: `addr` = `pc` if `immediate` else `x`. When `mem_ready`:
  - PC update: if `doJump`, `pc`<=`dbus`. Else if `immediate`, `pc`<=`pc`+1 (operand byte consumed). Else `pc` holds.
  - Next state: if `loadIR`, `ir`<=`dbus` and stay in EXEC (chained instruction, no FETCH cycle). Otherwise go to FETCH.
  - `instr_count`<=`instr_count`+1, including on the chained-loadIR path.
- `doJump` takes precedence over the immediate increment. `doJump` together with `loadIR` cannot occur, since dest differs.
- In FETCH, decoder-derived inputs are ignored.
- Arithmetic: `pc` is modulo 256 (0xFF+1 → 0x00). `instr_count` is modulo 65536 (0xFFFF → 0x0000).
- `mem_ready`=0 in any state: `pc`, `ir`, state and `instr_count` hold. `addr` keeps its combinational value.

## Timing
- `addr`, `exec` and `halted` are combinational from state/`pc`/`ir`/`x`. All other outputs are registered.
- Nominal instruction: 2 cycles (FETCH+EXEC). Each chained `loadIR` instruction: 1 cycle.
- Jump target is visible on `pc` the cycle after EXEC; the next FETCH addresses it.
- Each low cycle of `mem_ready` adds exactly one cycle; no state is lost.
- Reset asserted mid-EXEC: outputs take reset values immediately, without waiting for `clk`. The first FETCH after deassertion addresses 0x00.

## Configuration
- `SEQ_HALT_EN` defined:
  - In EXEC, `ir[3:1]`==7 (dest 7, unused by the decoder) with `mem_ready`=1 enters HALT. `instr_count` still increments.
  - HALT: `halted`=1, `exec`=0, `addr`=`pc`. Everything holds until reset.
- `SEQ_HALT_EN` undefined: dest 7 executes as a plain EXEC (PC rules above, then FETCH). The HALT state does not exist and `halted` is tied to 0.

## Test plan
- Reset then free-run with memory 0x00:0x0C, 0x01:0x55, `mem_ready`=1 (`ir`=0x0C: dest 6, immediate) → cycle 1 FETCH `addr`=0x00, `ir`=0x0C, `pc`=0x01. Cycle 2 EXEC `addr`=0x01, `pc`=0x02. `instr_count`=1.
- Indexed: `ir`=0x0D, `x`=0x80 → EXEC `addr`=0x80, `pc` unchanged, then FETCH.
- Jump: `doJump`=1, `dbus`=0x40 in EXEC → `pc`=0x40, next FETCH `addr`=0x40. Repeat with `pc`=0xFF on FETCH → `pc` wraps to 0x00.
- Chained load: EXEC with `loadIR`=1, `dbus`=0x2B → `ir`=0x2B, state stays EXEC, `instr_count`+1, no FETCH cycle.
- Stall: hold `mem_ready`=0 for 3 cycles mid-EXEC → `pc`/`ir`/`instr_count` unchanged, instruction completes on the 4th cycle. Assert `reset` asynchronously mid-EXEC → `pc`=0, `ir`=0, `exec`=0 before the next edge.
- With `SEQ_HALT_EN`: `ir`=0x0E executed → `halted`=1, `pc` frozen for 10 cycles. Without the macro: same stimulus → returns to FETCH, `halted`=0.
